// File: rtl/bsg_buf_ctrl_seq_pkg.sv
// Shared types and sizing helpers for the sequenced enable controller.
package bsg_buf_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } bsg_buf_ctrl_seq_state_e;

  // max(1, clog2(n)): a one-entry range still needs a one-bit register.
  function automatic int bsg_buf_ctrl_seq_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_buf_ctrl_seq_buf.sv
// One group of the replicated enable fanout: a single enable copied width_p times.
module bsg_buf_ctrl #(
  parameter int width_p = 16
) (
  input  logic               en_i,
  output logic [width_p-1:0] en_o
);

  assign en_o = {width_p{en_i}};

endmodule

// File: rtl/bsg_buf_ctrl_seq.sv
// Sequenced group enable controller: ramps groups on/off one at a time with a dwell.
// Optional macro BSG_BUF_CTRL_SEQ_ABORT_EN allows mid-ramp reversal.
module bsg_buf_ctrl_seq
  import bsg_buf_ctrl_seq_pkg::*;
#(
  parameter int width_p  = 64,
  parameter int groups_p = 4,
  parameter int dwell_p  = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                v_i,
  input  logic                on_i,
  output logic                ready_o,
  output logic [groups_p-1:0] grp_en_o,
  output logic [width_p-1:0]  en_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int grp_w_lp = width_p / groups_p;
  localparam int cnt_w_lp = bsg_buf_ctrl_seq_width(dwell_p);
  localparam int idx_w_lp = bsg_buf_ctrl_seq_width(groups_p);

  localparam logic [cnt_w_lp-1:0] dwell_last_lp = cnt_w_lp'(dwell_p - 1);
  localparam logic [idx_w_lp-1:0] idx_last_lp   = idx_w_lp'(groups_p - 1);
  localparam logic [groups_p-1:0] grp_one_lp    = groups_p'(1);

  bsg_buf_ctrl_seq_state_e state_r;
  logic [groups_p-1:0]     grp_en_r;
  logic [cnt_w_lp-1:0]     cnt_r;
  logic [idx_w_lp-1:0]     idx_r;
  logic                    busy_r;
  logic                    done_r;

  // idx_r tracks the highest enabled group; it saturates instead of wrapping.
  logic                    up_more;
  logic [idx_w_lp-1:0]     idx_dec;

  assign up_more = (grp_en_r == '0) || (idx_r != idx_last_lp);
  assign idx_dec = (idx_r == '0) ? '0 : idx_r - idx_w_lp'(1);

`ifdef BSG_BUF_CTRL_SEQ_ABORT_EN
  assign ready_o = 1'b1;
`else
  assign ready_o = (state_r == OFF) || (state_r == ON);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= OFF;
      grp_en_r <= '0;
      cnt_r    <= '0;
      idx_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        OFF: begin
          if (v_i) begin
            if (on_i) begin
              state_r  <= RAMP_UP;
              busy_r   <= 1'b1;
              grp_en_r <= grp_one_lp;
              idx_r    <= '0;
              cnt_r    <= dwell_last_lp;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ON: begin
          if (v_i) begin
            if (!on_i) begin
              state_r  <= RAMP_DOWN;
              busy_r   <= 1'b1;
              grp_en_r <= grp_en_r >> 1;
              idx_r    <= idx_dec;
              cnt_r    <= dwell_last_lp;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        RAMP_UP: begin
`ifdef BSG_BUF_CTRL_SEQ_ABORT_EN
          if (v_i && !on_i) begin
            state_r <= RAMP_DOWN;
            cnt_r   <= dwell_last_lp;
          end else
`endif
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - cnt_w_lp'(1);
          end else if (up_more) begin
            grp_en_r <= (grp_en_r << 1) | grp_one_lp;
            idx_r    <= (grp_en_r == '0) ? '0 : idx_r + idx_w_lp'(1);
            cnt_r    <= dwell_last_lp;
          end else begin
            state_r <= ON;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        RAMP_DOWN: begin
`ifdef BSG_BUF_CTRL_SEQ_ABORT_EN
          if (v_i && on_i) begin
            state_r <= RAMP_UP;
            cnt_r   <= dwell_last_lp;
          end else
`endif
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - cnt_w_lp'(1);
          end else if (grp_en_r != '0) begin
            grp_en_r <= grp_en_r >> 1;
            idx_r    <= idx_dec;
            cnt_r    <= dwell_last_lp;
          end else begin
            state_r <= OFF;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r  <= OFF;
          grp_en_r <= '0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign grp_en_o = grp_en_r;
  assign busy_o   = busy_r;
  assign done_o   = done_r;

  for (genvar g = 0; g < groups_p; g++) begin : g_buf
    bsg_buf_ctrl #(.width_p(grp_w_lp)) u_buf (
      .en_i (grp_en_r[g]),
      .en_o (en_o[g*grp_w_lp +: grp_w_lp])
    );
  end

endmodule

// File: doc/bsg_buf_ctrl_seq.md
Name: bsg_buf_ctrl_seq

Overview:
- Sequenced enable controller for wide replicated control fanout, e.g. clock-gate, power-switch or driver enables across a 64-bit bank.
- Splits the fanout into groups and turns groups on and off one at a time, with a programmable dwell between steps, to limit inrush and di/dt.
- Sits between a config/CSR requester (valid/ready) and the per-group control buffers.

Parameters:
- width_p, 64, total replicated enable width; must be divisible by groups_p.
- groups_p, 4, number of sequenced groups; must be at least 1.
- dwell_p, 8, cycles each group step is held before the next step; must be at least 1.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  1  request valid.
- on_i  input  1  requested target state: 1 = all on, 0 = all off.
- ready_o  output  1  request can be accepted this cycle.
- grp_en_o  output  groups_p  per-group enable; bit g drives group g.
- en_o  output  width_p  replicated enables; en_o[(g+1)*width_p/groups_p-1 : g*width_p/groups_p] = grp_en_o[g].
- busy_o  output  1  ramp in progress.
- done_o  output  1  one-cycle pulse when a request completes.

Behaviour:
- Single clock domain: clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: state OFF; grp_en_o = 0; en_o = 0; ready_o = 1; busy_o = 0; done_o = 0; group index and dwell counter = 0.
- Reset takes priority over everything. Asserting it mid-ramp forces all enables to 0 on the next edge; no done_o pulse.
- States: OFF, RAMP_UP, ON, RAMP_DOWN.
- ready_o = 1 only in OFF or ON. A request is accepted on v_i & ready_o. v_i with ready_o = 0 is dropped, not queued.
- Accepting a request whose target equals the current state (on_i = 1 in ON, on_i = 0 in OFF):
  - no state change;
  - done_o pulses on the next cycle.
- OFF + on_i = 1, accepted at cycle T:
  - go to RAMP_UP;
  - group 0 asserts at T+1, group k asserts at T+1+k*dwell_p;
  - after the last group's dwell expires, at T+1+groups_p*dwell_p: state = ON, done_o = 1 for one cycle, ready_o = 1.
- ON + on_i = 0: RAMP_DOWN, the mirror image of RAMP_UP.
  - Group groups_p-1 deasserts first, at T+1; group 0 deasserts last.
  - State = OFF and done_o pulses at T+1+groups_p*dwell_p.
- busy_o = 1 exactly in RAMP_UP and RAMP_DOWN.
- Dwell counter:
  - loads dwell_p-1 on each group step and decrements to 0;
  - width max(1, clog2(dwell_p));
  - group index width max(1, clog2(groups_p)).
- Wrap/boundary:
  - the index never wraps; it saturates at groups_p-1 (up) or 0 (down) while the final dwell runs;
  - dwell_p = 1 steps every cycle;
  - groups_p = 1 gives all bits switching together, with done_o dwell_p cycles later.
- grp_en_o is always thermometer-coded: groups 0..k on, the rest off. It never has holes.
- All outputs are registered except ready_o and en_o. Both are pure functions of registered state.

Optional Feature:
- Macro: BSG_BUF_CTRL_SEQ_ABORT_EN.
- With the macro defined:
  - ready_o is also 1 during RAMP_UP and RAMP_DOWN;
  - an accepted opposite-direction request reverses the ramp from the current thermometer position, starting next cycle with a fresh dwell_p count;
  - the in-progress request gets no done_o; only the new request's completion pulses done_o;
  - an accepted same-direction request mid-ramp is a no-op and gets no extra done_o.
- Without the macro: ready_o = 0 during ramps, as above.

Decomposition:
- Package bsg_buf_ctrl_seq_pkg holds:
  - the state enum bsg_buf_ctrl_seq_state_e (OFF, RAMP_UP, ON, RAMP_DOWN);
  - a width helper function for the counter and index widths.
- Sub-module: instantiate bsg_buf_ctrl groups_p times, each with width width_p/groups_p, driven by grp_en_o[g], to form en_o.
- The FSM and counters stay in the top module.

Test Plan:
- Defaults; after reset, v_i = 1, on_i = 1 at cycle 10 -> grp_en_o = 0001 @11, 0011 @19, 0111 @27, 1111 @35; done_o @43 only; en_o[15:0] all ones from 11; en_o = all ones from 35.
- From ON, on_i = 0 accepted at T -> grp_en_o = 0111 @T+1, 0011 @T+9, 0001 @T+17, 0000 @T+25; done_o @T+33; busy_o high T+1..T+32.
- In OFF, request on_i = 0 -> grp_en_o stays 0000; done_o @T+1; busy_o never asserts.
- v_i pulsed with on_i = 0 during RAMP_UP (no macro) -> ready_o = 0, request dropped, ramp completes exactly as in test 1. With BSG_BUF_CTRL_SEQ_ABORT_EN, same stimulus at grp_en_o = 0011 -> reversal, 0001 after 8 cycles, 0000 after 16, one done_o.
- reset_i asserted while grp_en_o = 0011 -> next cycle grp_en_o = 0, en_o = 0, ready_o = 1, no done_o; a subsequent on request ramps normally.
- groups_p = 1, dwell_p = 1, width_p = 8 -> on request at T gives en_o = 0xFF @T+1 and done_o @T+2; thermometer invariant checked by assertion on every cycle.
